rv_decode_stage: RTL and testbench

- Registered, handshaked RV32I/M decode stage between fetch and execute.
- Decodes each accepted instruction into a control bundle plus sign-extended immediate and register indices.
- Buffers results in a 2-entry skid buffer so `in_ready` is a pure register output.
- Generalises the combinational decoder:
  - XLEN-parametrised immediate.
  - Optional M-extension.
  - Illegal-instruction detection.
  - Flush.
  - Structural-hazard throttle for the multi-cycle multiplier/divider.

---
 rtl/rv_pkg.sv | 28 ++
 rtl/rv_decode_comb.sv | 87 ++++++++
 rtl/rv_decode_stage.sv | 96 +++++++++
 tb/tb_rv_decode_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: RV32I/M opcodes, control codes and the decoded control bundle
package rv_pkg;
  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR = 5'd3,
                         ALU_XOR = 5'd4, ALU_SLL = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
                         ALU_SLTU = 5'd8, ALU_SLT = 5'd9;
  localparam logic [4:0] MUL_MUL = 5'd10, MUL_MULH = 5'd11, MUL_MULHSU = 5'd12, MUL_MULHU = 5'd13,
                         MUL_DIV = 5'd14, MUL_DIVU = 5'd15, MUL_REM = 5'd16, MUL_REMU = 5'd17;
  localparam logic [4:0] BR_EQ = 5'd0, BR_NE = 5'd1, BR_LT = 5'd2, BR_GE = 5'd3,
                         BR_LTU = 5'd4, BR_GEU = 5'd5;
  localparam logic [1:0] RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10;
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] control;
    logic [1:0] result_src;
    logic       reg_write;
    logic       wed;
    logic       imm_src;
    logic       is_branch;
    logic       is_jmp;
    logic       is_jmpr;
    logic       illegal;
  } dec_bundle_t;
endpackage

// File: rtl/rv_decode_comb.sv
// rv_decode_comb: combinational RV32I/M instruction decoder with illegal detection
module rv_decode_comb
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0]     i_instr,
  output dec_bundle_t     o_dec,
  output logic [XLEN-1:0] o_imm,
  output logic            o_is_m
);
  logic [6:0] w_opc, w_f7;
  logic [2:0] w_f3;
  logic [4:0] w_alu, w_br, w_mul, w_ctrl;
  logic [31:0] w_imm32;
  logic w_op, w_opimm, w_load, w_store, w_branch, w_jal, w_jalr, w_m, w_op_ok, w_ill;
  assign w_opc    = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_op     = w_opc == OPC_OP;
  assign w_opimm  = w_opc == OPC_OPIMM;
  assign w_load   = w_opc == OPC_LOAD;
  assign w_store  = w_opc == OPC_STORE;
  assign w_branch = w_opc == OPC_BRANCH;
  assign w_jal    = w_opc == OPC_JAL;
  assign w_jalr   = w_opc == OPC_JALR;
  assign w_m      = w_op && w_f7 == 7'b0000001;
  assign w_op_ok  = w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))
                    || (EN_M && w_m);
  assign w_ill    = !(w_op || w_opimm || w_load || w_store || w_branch || w_jal || w_jalr)
                    || (w_op && !w_op_ok) || (w_branch && w_f3[2:1] == 2'b01);
  assign o_is_m   = EN_M && w_m;
  always_comb begin
    case (w_f3)
      3'b000:  w_alu = (w_op && i_instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu = ALU_SLL;
      3'b010:  w_alu = ALU_SLT;
      3'b011:  w_alu = ALU_SLTU;
      3'b100:  w_alu = ALU_XOR;
      3'b101:  w_alu = i_instr[30] ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu = ALU_OR;
      default: w_alu = ALU_AND;
    endcase
    case (w_f3)
      3'b001:  w_br = BR_NE;
      3'b100:  w_br = BR_LT;
      3'b101:  w_br = BR_GE;
      3'b110:  w_br = BR_LTU;
      3'b111:  w_br = BR_GEU;
      default: w_br = BR_EQ;
    endcase
    case (w_f3)
      3'b000:  w_mul = MUL_MUL;
      3'b001:  w_mul = MUL_MULH;
      3'b010:  w_mul = MUL_MULHSU;
      3'b011:  w_mul = MUL_MULHU;
      3'b100:  w_mul = MUL_DIV;
      3'b101:  w_mul = MUL_DIVU;
      3'b110:  w_mul = MUL_REM;
      default: w_mul = MUL_REMU;
    endcase
  end
  assign w_ctrl = w_m ? w_mul : (w_op || w_opimm) ? w_alu : w_branch ? w_br : ALU_ADD;
  always_comb begin
    o_dec            = '0;
    o_dec.rd         = i_instr[11:7];
    o_dec.rs1        = i_instr[19:15];
    o_dec.rs2        = i_instr[24:20];
    o_dec.control    = w_ill ? ALU_ADD : w_ctrl;
    o_dec.result_src = (w_jal || w_jalr) ? RES_PC4 : w_load ? RES_MEM : RES_ALU;
    o_dec.reg_write  = !w_ill && (w_op || w_opimm || w_jal || w_jalr || w_load);
    o_dec.wed        = !w_ill && w_store;
    o_dec.imm_src    = w_opimm || w_load || w_jalr || w_store || w_branch;
    o_dec.is_branch  = w_branch;
    o_dec.is_jmp     = w_jal;
    o_dec.is_jmpr    = w_jalr;
    o_dec.illegal    = w_ill;
  end
  // B and J immediates carry an implicit zero LSB
  assign w_imm32 = (w_opimm || w_load || w_jalr) ? {{20{i_instr[31]}}, i_instr[31:20]}
                 : w_store  ? {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]}
                 : w_branch ? {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}
                 : w_jal    ? {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}
                 : 32'd0;
  assign o_imm = XLEN'($signed(w_imm32));
endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered decode stage with 2-entry skid buffer and mul/div issue throttle
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_M    = 1'b1,
  parameter int MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_control,
  output logic [1:0]      out_result_src,
  output logic            out_reg_write,
  output logic            out_wed,
  output logic            out_imm_src,
  output logic            out_is_branch,
  output logic            out_is_jmp,
  output logic            out_is_jmpr,
  output logic            out_illegal
);
  localparam int BW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  typedef struct packed {
    dec_bundle_t     dec;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } entry_t;
  entry_t r_main, r_skid, w_new;
  dec_bundle_t w_dec;
  logic [XLEN-1:0] w_imm;
  logic [BW-1:0] r_busy;
  logic r_main_v, r_skid_v, r_in_ready, w_is_m, w_accept, w_load_main;
  rv_decode_comb #(.XLEN(XLEN), .EN_M(EN_M)) u_dec (
    .i_instr(in_instr),
    .o_dec  (w_dec),
    .o_imm  (w_imm),
    .o_is_m (w_is_m)
  );
  assign w_new       = '{dec: w_dec, imm: w_imm, pc: in_pc};
  // the throttle only masks acceptance so in_ready stays a clean register output
  assign w_accept    = in_valid && r_in_ready && !flush && !(w_is_m && r_busy != '0);
  assign w_load_main = !r_main_v || out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= '0;
    end else if (flush) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
      r_busy     <= '0;
    end else begin
      if (w_load_main) begin
        if (r_skid_v || w_accept) r_main <= r_skid_v ? r_skid : w_new;
        r_main_v   <= r_skid_v || w_accept;
        r_skid_v   <= 1'b0;
        r_in_ready <= 1'b1;
      end else if (w_accept) begin
        r_skid     <= w_new;
        r_skid_v   <= 1'b1;
        r_in_ready <= 1'b0;
      end else r_in_ready <= !r_skid_v;
      r_busy <= (w_accept && w_is_m) ? BW'(MUL_LAT - 1) : (r_busy != '0) ? r_busy - BW'(1) : r_busy;
    end
  assign in_ready       = r_in_ready;
  assign out_valid      = r_main_v;
  assign out_pc         = r_main.pc;
  assign out_imm        = r_main.imm;
  assign out_rd         = r_main.dec.rd;
  assign out_rs1        = r_main.dec.rs1;
  assign out_rs2        = r_main.dec.rs2;
  assign out_control    = r_main.dec.control;
  assign out_result_src = r_main.dec.result_src;
  assign out_reg_write  = r_main.dec.reg_write;
  assign out_wed        = r_main.dec.wed;
  assign out_imm_src    = r_main.dec.imm_src;
  assign out_is_branch  = r_main.dec.is_branch;
  assign out_is_jmp     = r_main.dec.is_jmp;
  assign out_is_jmpr    = r_main.dec.is_jmpr;
  assign out_illegal    = r_main.dec.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: scoreboard bench for the decode stage, plus an EN_M=0 instance
module tb_rv_decode_stage;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic in_ready, out_valid, out_reg_write, out_wed, out_imm_src, out_is_branch, out_is_jmp, out_is_jmpr, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0] out_rd, out_rs1, out_rs2, out_control;
  logic [1:0] out_result_src;
  logic in_valid_1 = 1'b0;
  logic [31:0] in_instr_1 = '0, in_pc_1 = '0;
  logic in_ready_1, out_valid_1, out_reg_write_1, out_wed_1, out_imm_src_1, out_is_branch_1, out_is_jmp_1, out_is_jmpr_1, out_illegal_1;
  logic [31:0] out_pc_1, out_imm_1;
  logic [4:0] out_rd_1, out_rs1_1, out_rs2_1, out_control_1;
  logic [1:0] out_result_src_1;
  logic [92:0] act, act_1;
  logic [92:0] exp_q[$];
  int pop_cyc[$];
  int checks = 0, errors = 0, cyc = 0, tb_busy = 0;
  logic cur_m = 1'b0, last_acc = 1'b0;

  rv_decode_stage #(.XLEN(32), .EN_M(1'b1), .MUL_LAT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_control(out_control), .out_result_src(out_result_src), .out_reg_write(out_reg_write),
    .out_wed(out_wed), .out_imm_src(out_imm_src), .out_is_branch(out_is_branch),
    .out_is_jmp(out_is_jmp), .out_is_jmpr(out_is_jmpr), .out_illegal(out_illegal));

  rv_decode_stage #(.XLEN(32), .EN_M(1'b0), .MUL_LAT(4)) dut_nom (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .in_instr(in_instr_1), .in_pc(in_pc_1), .out_valid(out_valid_1), .out_ready(1'b1),
    .out_pc(out_pc_1), .out_rd(out_rd_1), .out_rs1(out_rs1_1), .out_rs2(out_rs2_1), .out_imm(out_imm_1),
    .out_control(out_control_1), .out_result_src(out_result_src_1), .out_reg_write(out_reg_write_1),
    .out_wed(out_wed_1), .out_imm_src(out_imm_src_1), .out_is_branch(out_is_branch_1),
    .out_is_jmp(out_is_jmp_1), .out_is_jmpr(out_is_jmpr_1), .out_illegal(out_illegal_1));

  assign act = {out_pc, out_rd, out_rs1, out_rs2, out_imm, out_control, out_result_src,
                out_reg_write, out_wed, out_imm_src, out_is_branch, out_is_jmp, out_is_jmpr, out_illegal};
  assign act_1 = {out_pc_1, out_rd_1, out_rs1_1, out_rs2_1, out_imm_1, out_control_1, out_result_src_1,
                  out_reg_write_1, out_wed_1, out_imm_src_1, out_is_branch_1, out_is_jmp_1, out_is_jmpr_1, out_illegal_1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // flags = {reg_write, wed, imm_src, is_branch, is_jmp, is_jmpr, illegal}
  function automatic logic [92:0] mk(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] imm, input logic [4:0] c,
                                     input logic [1:0] r, input logic [6:0] f);
    return {pc, rd, rs1, rs2, imm, c, r, f};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h", act);
      end else begin
        logic [92:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL output pc=%h got=%h exp=%h", out_pc, act, e);
        end
      end
      pop_cyc.push_back(cyc);
    end

  // advance one cycle while tracking whether the offered input was taken
  task automatic tick();
    logic acc;
    acc = in_valid && in_ready && !flush && !(cur_m && tb_busy != 0);
    @(posedge clk);
    tb_busy = flush ? 0 : (acc && cur_m) ? 3 : (tb_busy > 0 ? tb_busy - 1 : 0);
    last_acc = acc;
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic m, input logic [92:0] e);
    int n = 0;
    in_valid = 1'b1; in_instr = ins; in_pc = pc; cur_m = m;
    do begin tick(); n++; end while (!last_acc && n < 20);
    in_valid = 1'b0; cur_m = 1'b0;
    chk("send_accept", last_acc, 1'b1);
    if (last_acc) exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int c0, n;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_fields", act, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_release_ready", in_ready, 1'b0);
    tick();
    chk("first_clk_ready", in_ready, 1'b1);
    chk("nom_ready", in_ready_1, 1'b1);
    in_valid_1 = 1'b1; in_instr_1 = 32'h02208033; in_pc_1 = 32'h200;
    @(posedge clk); #1;
    in_valid_1 = 1'b0;
    chk("nom_valid", out_valid_1, 1'b1);
    chk("nom_mul_bundle", act_1, mk(32'h200, 5'd0, 5'd1, 5'd2, 32'h0, 5'd0, 2'b00, 7'b0000001));
    // single addi: one-cycle latency
    c0 = cyc;
    send(32'h00500093, 32'h100, 1'b0, mk(32'h100, 5'd1, 5'd0, 5'd5, 32'd5, 5'd0, 2'b00, 7'b1010000));
    drain();
    chk("addi_latency", pop_cyc[pop_cyc.size()-1], c0 + 1);
    // format and opcode coverage, back to back
    send(32'h40208033, 32'h104, 1'b0, mk(32'h104, 5'd0, 5'd1, 5'd2, 32'h0, 5'd1, 2'b00, 7'b1000000));
    send(32'h40105093, 32'h108, 1'b0, mk(32'h108, 5'd1, 5'd0, 5'd1, 32'h401, 5'd7, 2'b00, 7'b1010000));
    send(32'h40000093, 32'h10c, 1'b0, mk(32'h10c, 5'd1, 5'd0, 5'd0, 32'h400, 5'd0, 2'b00, 7'b1010000));
    send(32'hFFC12283, 32'h110, 1'b0, mk(32'h110, 5'd5, 5'd2, 5'd28, 32'hFFFFFFFC, 5'd0, 2'b01, 7'b1010000));
    send(32'h00612423, 32'h114, 1'b0, mk(32'h114, 5'd8, 5'd2, 5'd6, 32'd8, 5'd0, 2'b00, 7'b0110000));
    send(32'hFE209CE3, 32'h118, 1'b0, mk(32'h118, 5'd25, 5'd1, 5'd2, 32'hFFFFFFF8, 5'd1, 2'b00, 7'b0011000));
    send(32'h010000EF, 32'h11c, 1'b0, mk(32'h11c, 5'd1, 5'd0, 5'd16, 32'd16, 5'd0, 2'b10, 7'b1000100));
    send(32'h00008067, 32'h120, 1'b0, mk(32'h120, 5'd0, 5'd1, 5'd0, 32'd0, 5'd0, 2'b10, 7'b1010010));
    send(32'hFFFFFFFF, 32'h124, 1'b0, mk(32'h124, 5'd31, 5'd31, 5'd31, 32'd0, 5'd0, 2'b00, 7'b0000001));
    send(32'h40209033, 32'h128, 1'b0, mk(32'h128, 5'd0, 5'd1, 5'd2, 32'd0, 5'd0, 2'b00, 7'b0000001));
    drain();
    // mul throttle: second mul waits MUL_LAT cycles, a plain op slips through
    send(32'h02208033, 32'h200, 1'b1, mk(32'h200, 5'd0, 5'd1, 5'd2, 32'd0, 5'd10, 2'b00, 7'b1000000));
    send(32'h02208033, 32'h204, 1'b1, mk(32'h204, 5'd0, 5'd1, 5'd2, 32'd0, 5'd10, 2'b00, 7'b1000000));
    drain();
    n = pop_cyc.size();
    chk("mul_gap", pop_cyc[n-1] - pop_cyc[n-2], 4);
    repeat (4) tick();
    send(32'h02208033, 32'h208, 1'b1, mk(32'h208, 5'd0, 5'd1, 5'd2, 32'd0, 5'd10, 2'b00, 7'b1000000));
    send(32'h00500093, 32'h20c, 1'b0, mk(32'h20c, 5'd1, 5'd0, 5'd5, 32'd5, 5'd0, 2'b00, 7'b1010000));
    send(32'h02209033, 32'h210, 1'b1, mk(32'h210, 5'd0, 5'd1, 5'd2, 32'd0, 5'd11, 2'b00, 7'b1000000));
    drain();
    n = pop_cyc.size();
    chk("addi_after_mul_gap", pop_cyc[n-2] - pop_cyc[n-3], 1);
    chk("mul_after_addi_gap", pop_cyc[n-1] - pop_cyc[n-3], 4);
    repeat (4) tick();
    // back-pressure: two entries held, third waits
    out_ready = 1'b0;
    send(32'h00500093, 32'h300, 1'b0, mk(32'h300, 5'd1, 5'd0, 5'd5, 32'd5, 5'd0, 2'b00, 7'b1010000));
    send(32'h40208033, 32'h304, 1'b0, mk(32'h304, 5'd0, 5'd1, 5'd2, 32'h0, 5'd1, 2'b00, 7'b1000000));
    chk("stall_ready_low", in_ready, 1'b0);
    in_valid = 1'b1; in_instr = 32'h40105093; in_pc = 32'h308;
    tick(); tick();
    chk("stall_ready_held", in_ready, 1'b0);
    chk("stall_head_pc", out_pc, 32'h300);
    out_ready = 1'b1;
    send(32'h40105093, 32'h308, 1'b0, mk(32'h308, 5'd1, 5'd0, 5'd1, 32'h401, 5'd7, 2'b00, 7'b1010000));
    drain();
    chk("stall_ready_back", in_ready, 1'b1);
    // flush with both entries full and the multiplier busy
    out_ready = 1'b0;
    send(32'h00500093, 32'h400, 1'b0, mk(32'h400, 5'd1, 5'd0, 5'd5, 32'd5, 5'd0, 2'b00, 7'b1010000));
    send(32'h02208033, 32'h404, 1'b1, mk(32'h404, 5'd0, 5'd1, 5'd2, 32'd0, 5'd10, 2'b00, 7'b1000000));
    chk("flush_pre_valid", out_valid, 1'b1);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h408;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    c0 = cyc;
    send(32'h02208033, 32'h40c, 1'b1, mk(32'h40c, 5'd0, 5'd1, 5'd2, 32'd0, 5'd10, 2'b00, 7'b1000000));
    drain();
    chk("flush_mul_immediate", pop_cyc[pop_cyc.size()-1], c0 + 1);
    // asynchronous reset with an entry in flight
    out_ready = 1'b0;
    send(32'h40105093, 32'h500, 1'b0, mk(32'h500, 5'd1, 5'd0, 5'd1, 32'h401, 5'd7, 2'b00, 7'b1010000));
    chk("pre_rst_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_fields", act, '0);
    chk("async_rst_ready", in_ready, 1'b0);
    exp_q.delete();
    tb_busy = 0;
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1'b1);
    send(32'h00500093, 32'h600, 1'b0, mk(32'h600, 5'd1, 5'd0, 5'd5, 32'd5, 5'd0, 2'b00, 7'b1010000));
    drain();
    repeat (3) tick();
    chk("no_stray_output", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end
endmodule
